// File: rtl/foc_sequencer_if.sv
// foc_sequencer_if: start/done/fault handshake bundle between the PWM period logic,
// the FOC stages and the sequencer.
interface foc_sequencer_if #(
   parameter int N_STAGE = 5
);
   logic               iStart;
   logic [N_STAGE-1:0] iStage_done;
   logic               iFault_clr;
   logic [N_STAGE-1:0] oStage_en;
   logic               oBusy;
   logic               oCycle_done;
   logic               oOverrun;
   logic               oFault;
   logic [3:0]         oFault_stage;
   logic [15:0]        oCycle_cnt;
   modport master (
      output iStart, iStage_done, iFault_clr,
      input  oStage_en, oBusy, oCycle_done, oOverrun, oFault, oFault_stage, oCycle_cnt
   );
   modport slave (
      input  iStart, iStage_done, iFault_clr,
      output oStage_en, oBusy, oCycle_done, oOverrun, oFault, oFault_stage, oCycle_cnt
   );
endinterface

// File: rtl/foc_sequencer.sv
// foc_sequencer: per-PWM-period scheduler that walks the FOC stage chain in order,
// supervising each stage with a timeout and latching a fault on expiry.
module foc_sequencer #(
   parameter int N_STAGE = 5,
   parameter int TIMEOUT = 255
) (
   input logic            iClk,
   input logic            iRst_n,
   foc_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RUN, GAP, DONE, FAULT} state_t;
   localparam logic [3:0] LAST = 4'(N_STAGE - 1);
   localparam logic [9:0] TMAX = 10'(TIMEOUT);
   state_t             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [9:0]         timer_q, timer_d;
   logic [15:0]        cycle_cnt_q, cycle_cnt_d;
   logic               overrun_q, overrun_d;
   logic [N_STAGE-1:0] sel;
   logic               hit;
   // One-hot mask of the active stage; done bits of other stages fall out here.
   assign sel = N_STAGE'(1) << idx_q;
   assign hit = |(bus.iStage_done & sel);
   assign bus.oCycle_cnt = cycle_cnt_q;
   assign bus.oOverrun   = overrun_q;
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         idx_q       <= '0;
         timer_q     <= '0;
         cycle_cnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         cycle_cnt_q <= cycle_cnt_d;
         overrun_q   <= overrun_d;
      end
   end
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      timer_d          = timer_q;
      cycle_cnt_d      = cycle_cnt_q;
      overrun_d        = bus.iStart && state_q != IDLE;
      bus.oStage_en    = '0;
      bus.oBusy        = 1'b0;
      bus.oCycle_done  = 1'b0;
      bus.oFault       = 1'b0;
      bus.oFault_stage = '0;
      case (state_q)
         IDLE: begin
            if (bus.iStart) begin
               idx_d   = '0;
               timer_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            bus.oStage_en = sel;
            bus.oBusy     = 1'b1;
            // A done on the expiry cycle still counts, so it is tested before the timer.
            if (hit) begin
               if (idx_q == LAST) begin
                  state_d     = DONE;
                  cycle_cnt_d = cycle_cnt_q + 16'd1;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = GAP;
               end
            end else begin
               timer_d = timer_q + 10'd1;
               if (timer_d == TMAX) state_d = FAULT;
            end
         end
         GAP: begin
            bus.oBusy = 1'b1;
            timer_d   = '0;
            state_d   = RUN;
         end
         DONE: begin
            bus.oCycle_done = 1'b1;
            state_d         = IDLE;
         end
         FAULT: begin
            bus.oFault       = 1'b1;
            bus.oFault_stage = idx_q;
            if (bus.iFault_clr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_foc_sequencer.sv
// tb_foc_sequencer: table-driven and randomized checks of foc_sequencer against
// per-trial timelines computed arithmetically from stage latencies.
module tb_foc_sequencer;
   localparam int N = 5;
   localparam int T = 8;
   localparam int W = 96;
   typedef struct {
      logic         start;
      logic [N-1:0] done;
      logic         clr;
      logic [N-1:0] en;
      logic         busy;
      logic         cd;
      logic         ovr;
      logic         flt;
      logic [3:0]   fs;
      logic [15:0]  cnt;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          passed = 0;
   logic [15:0] exp_cnt = '0;
   vec_t        tbl [17];
   foc_sequencer_if #(.N_STAGE(N)) bus ();
   foc_sequencer #(.N_STAGE(N), .TIMEOUT(T)) dut (.iClk(clk), .iRst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [28:0] dut_out();
      return {bus.oStage_en, bus.oBusy, bus.oCycle_done, bus.oOverrun, bus.oFault,
              bus.oFault_stage, bus.oCycle_cnt};
   endfunction
   function automatic vec_t mk(logic s, logic [N-1:0] d, logic [N-1:0] e, logic b, logic cd,
                               logic o, logic [15:0] cnt);
      return '{s, d, 1'b0, e, b, cd, o, 1'b0, 4'd0, cnt};
   endfunction
   task automatic chk(input string nm, input logic [28:0] act, input logic [28:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   task automatic drive(input logic s, input logic [N-1:0] d, input logic c);
      bus.iStart      = s;
      bus.iStage_done = d;
      bus.iFault_clr  = c;
   endtask
   // lat[i]: cycles from stage i enable rise to its done pulse; lat >= T never answers.
   // ovr_at: extra start cycle (-1 none, 0 random); rst_at: cycle to pulse reset (-1 none).
   task automatic run_trial(input string nm, input int lat [N], input int ovr_at,
                            input int clr_dly, input bit stray, input int rst_at);
      logic [N-1:0] e_en [W];
      logic [N-1:0] s_done [W];
      logic         e_busy [W], e_cd [W], e_ovr [W], e_flt [W], s_start [W], s_clr [W];
      logic [3:0]   e_fs [W];
      int           win_lo [N], win_hi [N];
      int           r, fin, busy_end, ov;
      bit           faulted;
      for (int c = 0; c < W; c++) begin
         e_en[c] = '0; s_done[c] = '0; e_busy[c] = 0; e_cd[c] = 0; e_ovr[c] = 0;
         e_flt[c] = 0; s_start[c] = 0; s_clr[c] = 0; e_fs[c] = '0;
      end
      for (int i = 0; i < N; i++) begin win_lo[i] = W; win_hi[i] = -1; end
      s_start[0] = 1;
      r = 1;
      faulted = 0;
      fin = 0;
      busy_end = 0;
      for (int i = 0; i < N; i++) begin
         win_lo[i] = r;
         if (lat[i] < T) begin
            win_hi[i] = r + lat[i];
            for (int c = r; c <= r + lat[i]; c++) e_en[c][i] = 1;
            s_done[r + lat[i]][i] = 1;
            r += lat[i] + 2;
         end else begin
            win_hi[i] = r + T - 1;
            for (int c = r; c < r + T; c++) e_en[c][i] = 1;
            for (int c = r + T; c <= r + T + clr_dly; c++) begin e_flt[c] = 1; e_fs[c] = 4'(i); end
            s_clr[r + T + clr_dly] = 1;
            busy_end = r + T - 1;
            fin = r + T + clr_dly;
            faulted = 1;
            break;
         end
      end
      if (!faulted) begin
         fin = r - 1;
         busy_end = fin - 1;
         e_cd[fin] = 1;
      end
      for (int c = 1; c <= busy_end; c++) e_busy[c] = 1;
      ov = ovr_at;
      if (ov == 0) ov = $urandom_range(0, 1) ? int'($urandom_range(1, fin)) : -1;
      if (ov > 0) begin s_start[ov] = 1; e_ovr[ov + 1] = 1; end
      if (stray)
         for (int c = 0; c <= fin + 2; c++)
            for (int j = 0; j < N; j++)
               if ((c < win_lo[j] || c > win_hi[j]) && $urandom_range(0, 9) == 0) s_done[c][j] = 1;
      for (int c = 0; c <= fin + 2; c++) begin
         @(negedge clk);
         chk($sformatf("%s c%0d", nm, c), dut_out(),
             {e_en[c], e_busy[c], e_cd[c], e_ovr[c], e_flt[c], e_fs[c],
              exp_cnt + 16'((!faulted && c >= fin) ? 1 : 0)});
         drive(s_start[c], s_done[c], s_clr[c]);
         if (c == rst_at) begin
            #1 rst_n = 1'b0;
            #1 chk($sformatf("%s async reset", nm), dut_out(), '0);
            drive(0, '0, 0);
            @(negedge clk) rst_n = 1'b1;
            exp_cnt = '0;
            return;
         end
      end
      if (!faulted) exp_cnt++;
   endtask
   initial begin
      int l [N];
      drive(0, '0, 0);
      tbl[0]  = mk(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
      tbl[1]  = mk(0, 5'b00000, 5'b00001, 1, 0, 0, 0);
      tbl[2]  = mk(0, 5'b00001, 5'b00001, 1, 0, 0, 0);
      tbl[3]  = mk(0, 5'b00000, 5'b00000, 1, 0, 0, 0);
      tbl[4]  = mk(0, 5'b01000, 5'b00010, 1, 0, 0, 0);
      tbl[5]  = mk(1, 5'b00010, 5'b00010, 1, 0, 0, 0);
      tbl[6]  = mk(0, 5'b00000, 5'b00000, 1, 0, 1, 0);
      tbl[7]  = mk(0, 5'b00000, 5'b00100, 1, 0, 0, 0);
      tbl[8]  = mk(0, 5'b00100, 5'b00100, 1, 0, 0, 0);
      tbl[9]  = mk(0, 5'b00000, 5'b00000, 1, 0, 0, 0);
      tbl[10] = mk(0, 5'b00000, 5'b01000, 1, 0, 0, 0);
      tbl[11] = mk(0, 5'b01000, 5'b01000, 1, 0, 0, 0);
      tbl[12] = mk(0, 5'b00000, 5'b00000, 1, 0, 0, 0);
      tbl[13] = mk(0, 5'b00000, 5'b10000, 1, 0, 0, 0);
      tbl[14] = mk(0, 5'b10000, 5'b10000, 1, 0, 0, 0);
      tbl[15] = mk(0, 5'b00000, 5'b00000, 0, 1, 0, 1);
      tbl[16] = mk(0, 5'b00000, 5'b00000, 0, 0, 0, 1);
      repeat (2) @(negedge clk);
      chk("reset state", dut_out(), '0);
      rst_n = 1'b1;
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         chk($sformatf("table c%0d", c), dut_out(),
             {tbl[c].en, tbl[c].busy, tbl[c].cd, tbl[c].ovr, tbl[c].flt, tbl[c].fs, tbl[c].cnt});
         drive(tbl[c].start, tbl[c].done, tbl[c].clr);
      end
      exp_cnt = 16'd1;
      run_trial("nominal", '{1, 1, 1, 1, 1}, -1, 0, 0, -1);
      run_trial("edge", '{1, 1, 3, 1, 1}, -1, 0, 0, -1);
      run_trial("timeout", '{1, 100, 1, 1, 1}, 13, 3, 0, -1);
      run_trial("timeout_clr_start", '{1, 100, 1, 1, 1}, 14, 2, 0, -1);
      run_trial("after_fault", '{1, 1, 1, 1, 1}, -1, 0, 0, -1);
      run_trial("boundary", '{1, T - 1, 1, 1, T - 1}, -1, 0, 0, -1);
      run_trial("stage0_timeout", '{T, 1, 1, 1, 1}, -1, 1, 0, -1);
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++)
            l[i] = ($urandom_range(0, 15) == 0) ? T + int'($urandom_range(0, 3))
                                                : int'($urandom_range(0, T - 1));
         run_trial($sformatf("rand%0d", k), l, 0, int'($urandom_range(0, 3)), 1, -1);
      end
      run_trial("reset_mid", '{1, 1, 1, 1, 1}, -1, 0, 0, 6);
      run_trial("after_reset", '{1, 1, 1, 1, 1}, -1, 0, 0, -1);
      @(negedge clk);
      force dut.cycle_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.cycle_cnt_q;
      exp_cnt = 16'hFFFE;
      run_trial("wrap_ffff", '{1, 1, 1, 1, 1}, -1, 0, 0, -1);
      run_trial("wrap_0000", '{1, 1, 1, 1, 1}, -1, 0, 0, -1);
      @(negedge clk);
      chk("wrap count", {13'd0, bus.oCycle_cnt}, 29'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
